instruction_encoder: RTL and testbench

Packs decoded RV32I fields and a full 32-bit immediate back into a 32-bit instruction word, and streams the result into instruction memory at consecutive word addresses. It is the inverse of the immediate generator: the immediate is given in the same form that `immediate_generator` outputs and is scattered into the format-specific bit positions. It sits between the debug/loader front end, which issues requests, and the instruction-memory write port.

---
 rtl/instruction_encoder.sv | 188 ++++++++++++++++++
 tb/tb_instruction_encoder.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: packs decoded fields plus a full immediate into a 32-bit word
// and streams encoded words into instruction memory at consecutive word addresses.
module instruction_encoder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [2:0]            req_format_i,
    input  logic [6:0]            req_opcode_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [6:0]            req_funct7_i,
    input  logic [4:0]            req_rd_i,
    input  logic [4:0]            req_rs1_i,
    input  logic [4:0]            req_rs2_i,
    input  logic [31:0]           req_imm_i,
    output logic                  wr_valid_o,
    input  logic                  wr_ready_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [31:0]           wr_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  full_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_FMT   = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;
    localparam logic [1:0] ERR_ALIGN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FULL  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wr_valid;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [31:0]           r_wr_data;
    logic [CNT_W-1:0]      r_count;
    logic                  r_full;
    logic                  r_err;
    logic [1:0]            r_err_code;

    logic        w_drain;
    logic        w_last_pending;
    logic        w_ready;
    logic        w_accept;
    logic        w_fmt_bad;
    logic        w_misalign;
    logic        w_range_bad;
    logic [1:0]  w_chk_code;
    logic [31:0] w_word;

    assign w_drain        = r_wr_valid && wr_ready_i;
    // The word at the last address must not be followed by another: the address never wraps.
    assign w_last_pending = r_wr_valid && (r_wr_addr == LAST_ADDR);
    assign w_ready        = (r_state == S_RUN) && !start_i && (!r_wr_valid || wr_ready_i)
                            && !w_last_pending;
    assign w_accept       = req_valid_i && w_ready;

    assign w_fmt_bad  = (req_format_i > FMT_J) || (req_opcode_i[1:0] != 2'b11);
    assign w_misalign = ((req_format_i == FMT_B) || (req_format_i == FMT_J)) && req_imm_i[0];

    // Immediate range check and first-failure-wins error cause
    always_comb begin
        w_range_bad = 1'b0;
        w_chk_code  = ERR_NONE;
        case (req_format_i)
            FMT_I, FMT_S: w_range_bad = (req_imm_i != {{20{req_imm_i[11]}}, req_imm_i[11:0]});
            FMT_B:        w_range_bad = (req_imm_i != {{19{req_imm_i[12]}}, req_imm_i[12:0]});
            FMT_J:        w_range_bad = (req_imm_i != {{11{req_imm_i[20]}}, req_imm_i[20:0]});
            FMT_U:        w_range_bad = (req_imm_i[11:0] != 12'd0);
            default:      w_range_bad = 1'b0;
        endcase
        if (w_fmt_bad) begin
            w_chk_code = ERR_FMT;
        end else if (w_misalign) begin
            w_chk_code = ERR_ALIGN;
        end else if (w_range_bad) begin
            w_chk_code = ERR_RANGE;
        end
    end

    // Scatter the immediate into its format-specific bit positions
    always_comb begin
        w_word = 32'd0;
        case (req_format_i)
            FMT_R: w_word = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
            FMT_I: w_word = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
            FMT_S: w_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i,
                             req_imm_i[4:0], req_opcode_i};
            FMT_B: w_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                             req_imm_i[4:1], req_imm_i[11], req_opcode_i};
            FMT_U: w_word = {req_imm_i[31:12], req_rd_i, req_opcode_i};
            FMT_J: w_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                             req_rd_i, req_opcode_i};
            default: w_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start_i) begin
            w_state_nxt = S_RUN;
        end else if (r_state == S_RUN) begin
            if (w_accept && (w_chk_code != ERR_NONE)) begin
                w_state_nxt = S_ERROR;
            end else if (w_drain && (r_wr_addr == LAST_ADDR)) begin
                w_state_nxt = S_FULL;
            end
        end
    end

    // Output register, address/count tracking and sticky error
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else if (start_i) begin
            r_wr_valid <= 1'b0;
            r_wr_addr  <= ADDR_WIDTH'(BASE_ADDR);
            r_count    <= '0;
            r_full     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_drain) begin
                r_count <= r_count + CNT_W'(1);
                if (r_wr_addr == LAST_ADDR) begin
                    r_full <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                end
            end
            if (w_accept && (w_chk_code == ERR_NONE)) begin
                r_wr_valid <= 1'b1;
                r_wr_data  <= w_word;
            end else if (w_drain) begin
                r_wr_valid <= 1'b0;
            end
            if (w_accept && (w_chk_code != ERR_NONE)) begin
                r_err      <= 1'b1;
                r_err_code <= w_chk_code;
            end
        end
    end

    assign req_ready_o = w_ready;
    assign wr_valid_o  = r_wr_valid;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign count_o     = r_count;
    assign full_o      = r_full;
    assign err_o       = r_err;
    assign err_code_o  = r_err_code;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: table-driven encodes and errors, backpressure,
// full/restart/reset corner cases and a scoreboarded random round trip through an imm decoder.
module tb_instruction_encoder;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        bit          has_word;
        logic [31:0] word;
        logic [1:0]  code;
        int          addr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_start;
    logic        req_valid;
    logic [2:0]  req_format;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        wr_ready;

    logic        req_ready;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [10:0] count;
    logic        full;
    logic        err;
    logic [1:0]  err_code;

    logic        s_req_ready;
    logic        s_wr_valid;
    logic [1:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic [2:0]  s_count;
    logic        s_full;
    logic        s_err;
    logic [1:0]  s_err_code;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_addr = 0;
    int   s_exp_addr = 0;
    bit   rand_ready = 1'b0;
    ent_t sb[$];
    ent_t sb_s[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instruction_encoder #(.ADDR_WIDTH(10), .BASE_ADDR(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_format_i(req_format), .req_opcode_i(req_opcode),
        .req_funct3_i(req_funct3), .req_funct7_i(req_funct7),
        .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_imm_i(req_imm),
        .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
        .count_o(count), .full_o(full), .err_o(err), .err_code_o(err_code)
    );

    instruction_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) u_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start),
        .req_valid_i(req_valid), .req_ready_o(s_req_ready),
        .req_format_i(req_format), .req_opcode_i(req_opcode),
        .req_funct3_i(req_funct3), .req_funct7_i(req_funct7),
        .req_rd_i(req_rd), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_imm_i(req_imm),
        .wr_valid_o(s_wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(s_wr_addr),
        .wr_data_o(s_wr_data), .count_o(s_count), .full_o(s_full), .err_o(s_err),
        .err_code_o(s_err_code)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference immediate generator (inverse of the encoder's scatter)
    function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] w);
        case (fmt)
            3'd1:    return {{20{w[31]}}, w[31:20]};
            3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    return {w[31:12], 12'b0};
            3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_ent(input ent_t e, input logic [31:0] a, input logic [31:0] w);
        check("wr_addr", a, 32'(e.addr));
        if (e.has_word) begin
            check("wr_data", w, e.word);
        end else begin
            check("rt_opcode", 32'(w[6:0]), 32'(e.op));
            if (e.fmt != 3'd0) check("rt_imm", decode_imm(e.fmt, w), e.imm);
            if (e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) check("rt_rd", 32'(w[11:7]), 32'(e.rd));
            if (e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3}) begin
                check("rt_f3", 32'(w[14:12]), 32'(e.f3));
                check("rt_rs1", 32'(w[19:15]), 32'(e.rs1));
            end
            if (e.fmt inside {3'd0, 3'd2, 3'd3}) check("rt_rs2", 32'(w[24:20]), 32'(e.rs2));
            if (e.fmt == 3'd0) check("rt_f7", 32'(w[31:25]), 32'(e.f7));
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wr_valid && wr_ready) begin
            if (sb.size() == 0) check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            else check_ent(sb.pop_front(), 32'(wr_addr), wr_data);
        end
        if (!rst && s_wr_valid && wr_ready) begin
            if (sb_s.size() == 0) check("s_unexpected_write", 32'(s_wr_addr), 32'hFFFF_FFFF);
            else check_ent(sb_s.pop_front(), 32'(s_wr_addr), s_wr_data);
        end
    end

    function automatic ent_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                input logic [31:0] word, input logic [1:0] code);
        ent_t e;
        e.fmt = fmt; e.op = op; e.f3 = f3; e.f7 = f7; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.has_word = 1'b1; e.word = word; e.code = code; e.addr = 0;
        return e;
    endfunction

    function automatic ent_t rand_req();
        ent_t        e;
        logic [12:0] b;
        logic [20:0] j;
        logic [11:0] i12;
        e.fmt = 3'($urandom_range(0, 5));
        e.op  = {5'($urandom), 2'b11};
        e.f3  = 3'($urandom); e.f7 = 7'($urandom);
        e.rd  = 5'($urandom); e.rs1 = 5'($urandom); e.rs2 = 5'($urandom);
        i12 = 12'($urandom);
        b   = 13'($urandom) & 13'h1FFE;
        j   = 21'($urandom) & 21'h1FFFFE;
        case (e.fmt)
            3'd1, 3'd2: e.imm = {{20{i12[11]}}, i12};
            3'd3:       e.imm = {{19{b[12]}}, b};
            3'd4:       e.imm = {20'($urandom), 12'd0};
            3'd5:       e.imm = {{11{j[20]}}, j};
            default:    e.imm = $urandom;
        endcase
        e.has_word = 1'b0; e.word = 32'd0; e.code = 2'd0; e.addr = 0;
        return e;
    endfunction

    task automatic drive(input ent_t e);
        req_format = e.fmt; req_opcode = e.op; req_funct3 = e.f3; req_funct7 = e.f7;
        req_rd = e.rd; req_rs1 = e.rs1; req_rs2 = e.rs2; req_imm = e.imm;
    endtask

    // Present a request until accepted; legal ones are pushed to the scoreboard of the chosen DUT
    task automatic send(input ent_t e, input bit expect_ok, input bit sel);
        int   n = 0;
        ent_t x = e;
        drive(e);
        req_valid = 1'b1;
        forever begin
            if (rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if ((sel ? s_req_ready : req_ready) == 1'b1) break;
            n++;
            if (n > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout: request never accepted (t=%0t)", $time);
                req_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        if (expect_ok) begin
            if (sel) begin x.addr = s_exp_addr; s_exp_addr++; sb_s.push_back(x); end
            else     begin x.addr = exp_addr;   exp_addr++;   sb.push_back(x);   end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) s_start = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0; start = 1'b0;
        if (sel) begin sb_s.delete(); s_exp_addr = 0; end
        else     begin sb.delete();   exp_addr = 0;   end
    endtask

    task automatic wait_drain();
        int n = 0;
        wr_ready = 1'b1;
        while (sb.size() != 0 || sb_s.size() != 0) begin
            n++;
            if (n > 50) begin
                n_cmp++; n_bad++;
                $display("FAIL drain_timeout: %0d words still expected", sb.size() + sb_s.size());
                sb.delete(); sb_s.delete();
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd0);
        check({pfx, "_wr_valid"}, 32'(wr_valid), 32'd0);
        check({pfx, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({pfx, "_wr_data"}, wr_data, 32'd0);
        check({pfx, "_count"}, 32'(count), 32'd0);
        check({pfx, "_full"}, 32'(full), 32'd0);
        check({pfx, "_err"}, 32'(err), 32'd0);
        check({pfx, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t basic[5];
        ent_t errs[4];
        ent_t ea;
        ent_t eb;
        ent_t e5;
        int   c0;

        basic[0] = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,         32'h0050_0093, 2'd0);
        basic[1] = mk(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,         32'h0020_A423, 2'd0);
        basic[2] = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 2'd0);
        basic[3] = mk(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h0010_00EF, 2'd0);
        basic[4] = mk(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
        errs[0]  = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048,      32'd0, 2'd2);
        errs[1]  = mk(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3,         32'd0, 2'd3);
        errs[2]  = mk(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0,         32'd0, 2'd1);
        errs[3]  = mk(3'd1, 7'h10, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1,         32'd0, 2'd1);
        ea = mk(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd1, 5'd0, 32'hFFFF_FFFF, 32'hFFF0_8113, 2'd0);
        eb = mk(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0,         32'h4020_81B3, 2'd0);

        rst = 1'b1; start = 1'b0; s_start = 1'b0; req_valid = 1'b0; wr_ready = 1'b1;
        drive(basic[0]);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Full on the 4-word instance; the main instance stays IDLE and ignores requests
        pulse_start(1'b1);
        for (int i = 0; i < 4; i++) send(basic[i], 1'b1, 1'b1);
        drive(basic[4]);
        req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_req_ready", 32'(s_req_ready), 32'd0);
        end
        check("full_flag", 32'(s_full), 32'd1);
        check("full_count", 32'(s_count), 32'd4);
        check("full_main_idle_count", 32'(count), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_drain();
        pulse_start(1'b1);
        @(negedge clk);
        check("restart_addr", 32'(s_wr_addr), 32'd0);
        check("restart_count", 32'(s_count), 32'd0);
        check("restart_full", 32'(s_full), 32'd0);
        @(posedge clk); #1;
        send(basic[0], 1'b1, 1'b1);
        wait_drain();
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Basic encodes, one per cycle
        pulse_start(1'b0);
        @(negedge clk);
        check("start_ready", 32'(req_ready), 32'd1);
        check("start_addr", 32'(wr_addr), 32'd0);
        @(posedge clk); #1;
        c0 = cyc;
        for (int i = 0; i < 5; i++) send(basic[i], 1'b1, 1'b0);
        check("basic_cycles", 32'(cyc - c0), 32'd5);
        wait_drain();
        @(negedge clk);
        check("basic_count", 32'(count), 32'd5);
        @(posedge clk); #1;

        // Backpressure: second request waits, first word held stable
        pulse_start(1'b0);
        wr_ready = 1'b0;
        send(ea, 1'b1, 1'b0);
        drive(eb);
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_wr_valid", 32'(wr_valid), 32'd1);
            check("bp_wr_data", wr_data, ea.word);
            check("bp_wr_addr", 32'(wr_addr), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wr_ready = 1'b1;
        send(eb, 1'b1, 1'b0);
        wait_drain();

        // Error table: consumed, no write, ready low until start
        for (int i = 0; i < 4; i++) begin
            pulse_start(1'b0);
            send(errs[i], 1'b0, 1'b0);
            @(negedge clk);
            check("err_flag", 32'(err), 32'd1);
            check("err_code", 32'(err_code), 32'(errs[i].code));
            check("err_ready", 32'(req_ready), 32'd0);
            check("err_no_write", 32'(wr_valid), 32'd0);
            check("err_count", 32'(count), 32'd0);
            @(posedge clk); #1;
        end

        // Start while a word is pending and blocked: word dropped
        pulse_start(1'b0);
        wr_ready = 1'b0;
        send(ea, 1'b1, 1'b0);
        pulse_start(1'b0);
        @(negedge clk);
        check("drop_wr_valid", 32'(wr_valid), 32'd0);
        check("drop_err", 32'(err), 32'd0);
        wr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send(eb, 1'b1, 1'b0);
        wait_drain();

        // Asynchronous reset with a word pending
        pulse_start(1'b0);
        send(ea, 1'b1, 1'b0);
        send(eb, 1'b1, 1'b0);
        wait_drain();
        wr_ready = 1'b0;
        send(ea, 1'b1, 1'b0);
        @(negedge clk);
        check("pre_rst_count", 32'(count), 32'd2);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        sb.delete(); exp_addr = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Random round trip through the reference immediate generator
        pulse_start(1'b0);
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            e5 = rand_req();
            send(e5, 1'b1, 1'b0);
        end
        rand_ready = 1'b0;
        wait_drain();
        @(negedge clk);
        check("rt_count", 32'(count), 32'd1000);
        check("rt_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
